regfile_wport: RTL and testbench

REGFILE_WPORT -- requirements
Module: regfile_wport

---
 rtl/regfile_wport.sv | 98 +++++++++
 tb/tb_regfile_wport.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport.sv
// Register file write port: writes queue in a small FIFO and retire one per cycle into
// the register array. Register 0 is hardwired to zero.
module regfile_wport #(
  parameter int NREG  = 32,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      ctrl_reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(NREG)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      hold,
  input  logic                      flush,
  output logic [NREG*WIDTH-1:0]     regs_flat,
  output logic                      commit,
  output logic [$clog2(NREG)-1:0]   commit_addr,
  output logic [$clog2(DEPTH):0]    pending
);

  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    fifo_addr [DEPTH];
  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] regs [1:NREG-1];

  logic             push;
  logic             pop;
  logic [AW-1:0]    head_addr;
  logic [WIDTH-1:0] head_data;
  logic [NREG-1:1]  wsel;

  // Ready looks only at the registered count, so a same-cycle pop never frees a full slot.
  assign wr_ready  = ctrl_reset_n && (count < CW'(DEPTH)) && !flush;
  assign push      = wr_valid && wr_ready;
  assign pop       = (count != '0) && !hold && !flush;
  assign head_addr = fifo_addr[rptr];
  assign head_data = fifo_data[rptr];
  assign pending   = count;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      commit      <= 1'b0;
      commit_addr <= '0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      commit <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count  <= count + CW'(push) - CW'(pop);
      commit <= pop;
      if (pop) commit_addr <= head_addr;
    end
  end

  // FIFO payload carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= wr_data;
    end
  end

  always_comb begin
    wsel = '0;
    for (int k = 1; k < NREG; k++) begin
      wsel[k] = pop && (head_addr == AW'(k));
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int k = 1; k < NREG; k++) regs[k] <= '0;
    end else begin
      for (int k = 1; k < NREG; k++) begin
        if (wsel[k]) regs[k] <= head_data;
      end
    end
  end

  assign regs_flat[WIDTH-1:0] = '0;
  for (genvar k = 1; k < NREG; k++) begin : g_flat
    assign regs_flat[k*WIDTH +: WIDTH] = regs[k];
  end

endmodule

// File: tb/tb_regfile_wport.sv
// Randomized bench for regfile_wport against a queue-based reference model, with
// directed sequences pinning the key behaviours to literal values.
module tb_regfile_wport;

  localparam int NREG  = 32;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic              clock;
  logic              ctrl_reset_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              hold;
  logic              flush;
  logic [NREG*WIDTH-1:0] regs_flat;
  logic              commit;
  logic [4:0]        commit_addr;
  logic [1:0]        pending;

  regfile_wport #(.NREG(NREG), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .ctrl_reset_n(ctrl_reset_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .hold        (hold),
    .flush       (flush),
    .regs_flat   (regs_flat),
    .commit      (commit),
    .commit_addr (commit_addr),
    .pending     (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mreg [NREG];
  logic        mcommit;
  logic [4:0]  mcaddr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs();
    int first;
    first = -1;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (regs_flat[k*WIDTH +: WIDTH] !== mreg[k]) first = k;
    end
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL regs[%0d]: got %0h expected %0h at %0t",
               first, regs_flat[first*WIDTH +: WIDTH], mreg[first], $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < NREG; k++) mreg[k] = '0;
    mcommit = 1'b0;
    mcaddr  = '0;
  endtask

  // What one rising edge does to the architectural state, given the inputs present at it.
  task automatic model_edge(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic h, input logic f);
    bit   room;
    ent_t e;
    if (f) begin
      q.delete();
      mcommit = 1'b0;
    end else begin
      room = (q.size() < DEPTH);
      if (q.size() > 0 && !h) begin
        e = q.pop_front();
        if (e.a != 0) mreg[e.a] = e.d;
        mcommit = 1'b1;
        mcaddr  = e.a;
      end else begin
        mcommit = 1'b0;
      end
      if (v && room) begin
        e.a = a;
        e.d = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    chk("pending", 64'(pending), 64'(q.size()));
    chk("commit", 64'(commit), 64'(mcommit));
    chk("commit_addr", 64'(commit_addr), 64'(mcaddr));
    chk_regs();
  endtask

  // Called just after a falling edge; leaves time at the next falling edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic h, input logic f);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    hold     = h;
    flush    = f;
    #1;
    chk("wr_ready", 64'(wr_ready), 64'((q.size() < DEPTH) && !f));
    @(posedge clock);
    model_edge(v, a, d, h, f);
    @(negedge clock);
    check_all();
  endtask

  // Reset pulse entirely inside the low clock phase.
  task automatic pulse_reset();
    #1 ctrl_reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_regs_zero", 64'(regs_flat == '0), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_commit", 64'(commit), 64'd0);
    chk("rst_commit_addr", 64'(commit_addr), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk_regs();
    #1 ctrl_reset_n = 1'b1;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    hold     = 1'b0;
    flush    = 1'b0;
    model_reset();

    #2;
    check_all();
    chk("reset_ready", 64'(wr_ready), 64'd0);
    chk("reset_flat", 64'(regs_flat == '0), 64'd1);
    @(negedge clock);
    #2 ctrl_reset_n = 1'b1;

    // Basic write with one-edge retire latency
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("lat_pending", 64'(pending), 64'd1);
    chk("lat_no_commit", 64'(commit), 64'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("w5_commit", 64'(commit), 64'd1);
    chk("w5_addr", 64'(commit_addr), 64'd5);
    chk("w5_data", 64'(regs_flat[5*WIDTH +: WIDTH]), 64'hDEADBEEF);
    chk("w5_r4", 64'(regs_flat[4*WIDTH +: WIDTH]), 64'd0);

    // Write to register 0 retires but stores nothing
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("w0_commit", 64'(commit), 64'd1);
    chk("w0_addr", 64'(commit_addr), 64'd0);
    chk("w0_r0", 64'(regs_flat[WIDTH-1:0]), 64'd0);

    // Fill under hold, then drain in order
    step(1'b1, 5'd3, 32'h11, 1'b1, 1'b0);
    step(1'b1, 5'd4, 32'h22, 1'b1, 1'b0);
    step(1'b1, 5'd9, 32'h33, 1'b1, 1'b0);
    chk("full_pending", 64'(pending), 64'd2);
    chk("full_ready", 64'(wr_ready), 64'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("drain1_addr", 64'(commit_addr), 64'd3);
    chk("drain1_ready", 64'(wr_ready), 64'd1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("drain2_addr", 64'(commit_addr), 64'd4);
    chk("drain2_r3", 64'(regs_flat[3*WIDTH +: WIDTH]), 64'h11);
    chk("drain2_r4", 64'(regs_flat[4*WIDTH +: WIDTH]), 64'h22);

    // Same address twice: later value persists
    step(1'b1, 5'd7, 32'hA, 1'b1, 1'b0);
    step(1'b1, 5'd7, 32'hB, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("same_addr_r7", 64'(regs_flat[7*WIDTH +: WIDTH]), 64'hB);

    // Flush discards buffered writes
    step(1'b1, 5'd9, 32'hAA, 1'b1, 1'b0);
    step(1'b1, 5'd10, 32'hBB, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    chk("flush_pending", 64'(pending), 64'd0);
    chk("flush_commit", 64'(commit), 64'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("flush_no_commit", 64'(commit), 64'd0);
    chk("flush_r9", 64'(regs_flat[9*WIDTH +: WIDTH]), 64'd0);
    chk("flush_r10", 64'(regs_flat[10*WIDTH +: WIDTH]), 64'd0);

    // Asynchronous reset between edges with a write buffered
    step(1'b1, 5'd12, 32'h12345678, 1'b1, 1'b0);
    chk("pre_rst_pending", 64'(pending), 64'd1);
    pulse_reset();
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_commit", 64'(commit), 64'd0);
    chk("post_rst_r12", 64'(regs_flat[12*WIDTH +: WIDTH]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 31)),
           $urandom(),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
